// File: rtl/uart_ascii_tx_if.sv
// Byte-strobe input and status/serial output bundle of the ASCII UART transmitter.
// master = display-driver side, slave = transmitter.
interface uart_ascii_tx_if;
  logic [7:0] byte_in;
  logic       byte_stb;
  logic       ovf_clr;
  logic       txd;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  modport master (
    output byte_in, byte_stb, ovf_clr,
    input  txd, busy, fifo_full, overflow
  );

  modport slave (
    input  byte_in, byte_stb, ovf_clr,
    output txd, busy, fifo_full, overflow
  );
endinterface

// File: rtl/uart_ascii_tx.sv
// Buffers strobed ASCII bytes in a small FIFO and serializes them as 8N1 UART.
// txd is registered from the current FSM state, so the line lags the state by one cycle.
module uart_ascii_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_ascii_tx_if.slave bus
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            baud_wrap;
  logic            full_now;
  logic            pop;
  logic            wr;
  logic            drop;

  always_comb begin
    baud_wrap = (baud_cnt == CW'(DIV - 1));
    full_now  = (count == (AW+1)'(FIFO_DEPTH));
    pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_wrap));
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    wr        = bus.byte_stb && (!full_now || pop);
    drop      = bus.byte_stb && full_now && !pop;
    count_nxt = count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
  end

  // Byte storage and shift register carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (wr)  mem[wr_ptr] <= bus.byte_in;
    if (pop) shreg       <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.fifo_full <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count         <= count_nxt;
      bus.fifo_full <= (count_nxt == (AW+1)'(FIFO_DEPTH));
      if (drop)             bus.overflow <= 1'b1;
      else if (bus.ovf_clr) bus.overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      bus.txd  <= 1'b1;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        START:   bus.txd <= 1'b0;
        DATA:    bus.txd <= shreg[bit_idx];
        default: bus.txd <= 1'b1;
      endcase

      if (state == IDLE) baud_cnt <= '0;
      else               baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;

      bus.busy <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) state    <= START;
          else     bus.busy <= (count_nxt != '0);
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          // Chaining straight into START keeps back-to-back frames gapless.
          if (baud_wrap) begin
            if (pop) state <= START;
            else begin
              state    <= IDLE;
              bus.busy <= (count_nxt != '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ascii_tx.sv
// Directed bench for uart_ascii_tx: table of single-frame waveforms plus
// hand-written sequences for back-to-back, overflow, coincident pop/write and reset.
module tb_uart_ascii_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_ascii_tx_if bus ();

  uart_ascii_tx #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait until just after the posedge that brings cyc to tgt.
  task automatic wait_cyc(input int tgt);
    while (cyc < tgt) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit         mon_en = 1'b1;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  // Line decoder: samples each bit mid-period on the falling clock edge.
  initial forever begin
    @(negedge clk);
    if (mon_en && bus.txd === 1'b0) begin
      int         t0;
      logic [7:0] b;
      t0 = cyc;
      repeat (5) @(negedge clk);
      chk("mon_start_bit", bus.txd, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        b[i] = bus.txd;
      end
      repeat (10) @(negedge clk);
      chk("mon_stop_bit", bus.txd, 1'b1);
      rx_q.push_back(b);
      rx_t.push_back(t0);
    end
  end

  typedef struct {
    logic [7:0] b;
    logic [9:0] line;
    int         busy_len;
  } vec_t;

  vec_t tv[6];
  logic [7:0] exp2[4];
  logic [7:0] exp3[6];

  initial begin
    int s0;
    int wave_err;
    int busy_cnt;
    int fall_c;

    // line[k] is the txd level during bit period k: start, d0..d7, stop.
    tv[0] = '{8'h30, 10'h260, 101};
    tv[1] = '{8'h0D, 10'h21A, 101};
    tv[2] = '{8'h39, 10'h272, 101};
    tv[3] = '{8'hFF, 10'h3FE, 101};
    tv[4] = '{8'h00, 10'h200, 101};
    tv[5] = '{8'hA5, 10'h34A, 101};
    exp2  = '{8'h32, 8'h35, 8'h37, 8'h0D};
    exp3  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h39};

    bus.byte_in  = 8'h00;
    bus.byte_stb = 1'b0;
    bus.ovf_clr  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", bus.txd, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_fifo_full", bus.fifo_full, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single frames from idle, checked cycle by cycle.
    for (int i = 0; i < 6; i++) begin
      bus.byte_in  = tv[i].b;
      bus.byte_stb = 1'b1;
      @(posedge clk);
      #1;
      bus.byte_stb = 1'b0;
      bus.byte_in  = ~tv[i].b;
      wave_err = 0;
      busy_cnt = int'(bus.busy);
      fall_c   = -1;
      for (int c = 2; c <= 110; c++) begin
        @(posedge clk);
        #1;
        busy_cnt += int'(bus.busy);
        if (fall_c < 0 && bus.txd === 1'b0) fall_c = c;
        if (c >= 3 && c <= 102) begin
          if (bus.txd !== tv[i].line[(c-3)/10]) wave_err++;
        end else if (bus.txd !== 1'b1) begin
          wave_err++;
        end
      end
      chk($sformatf("fall_latency[%0d]", i), fall_c - 1, 2);
      chk($sformatf("txd_wave[%0d]", i), wave_err, 0);
      chk($sformatf("busy_len[%0d]", i), busy_cnt, tv[i].busy_len);
    end

    // Four consecutive strobes -> four gapless frames.
    rx_q.delete();
    rx_t.delete();
    s0 = 0;
    for (int k = 0; k < 4; k++) begin
      bus.byte_in  = exp2[k];
      bus.byte_stb = 1'b1;
      @(posedge clk);
      #1;
      if (k == 0) s0 = cyc;
    end
    bus.byte_stb = 1'b0;
    wait_cyc(s0 + 399);
    chk("b2b_busy_mid", bus.busy, 1'b1);
    wait_cyc(s0 + 420);
    chk("b2b_count", rx_q.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("b2b_byte[%0d]", k), (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp2[k]);
    chk("b2b_first_start", (rx_t.size() > 0) ? rx_t[0] : -1, s0 + 2);
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b_gap[%0d]", k), (k < rx_t.size()) ? rx_t[k] - rx_t[k-1] : -1, 100);
    chk("b2b_overflow", bus.overflow, 1'b0);
    chk("b2b_busy_end", bus.busy, 1'b0);

    // Six strobes: fill, drop, clear, coincident pop/write, drop with clear.
    rx_q.delete();
    rx_t.delete();
    for (int k = 0; k < 6; k++) begin
      bus.byte_in  = 8'h41 + 8'(k);
      bus.byte_stb = 1'b1;
      @(posedge clk);
      #1;
      if (k == 0) s0 = cyc;
      if (k == 3) chk("fill_full_e4", bus.fifo_full, 1'b0);
      if (k == 4) chk("fill_full_e5", bus.fifo_full, 1'b1);
    end
    bus.byte_stb = 1'b0;
    chk("drop_overflow", bus.overflow, 1'b1);
    chk("drop_full", bus.fifo_full, 1'b1);

    wait_cyc(s0 + 48);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_alone", bus.overflow, 1'b0);

    wait_cyc(s0 + 100);
    bus.byte_in  = 8'h39;
    bus.byte_stb = 1'b1;
    @(posedge clk);
    #1;
    chk("popwr_full", bus.fifo_full, 1'b1);
    chk("popwr_overflow", bus.overflow, 1'b0);
    bus.byte_in = 8'h58;
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_stb = 1'b0;
    bus.ovf_clr  = 1'b0;
    chk("drop_with_clr_overflow", bus.overflow, 1'b1);

    wait_cyc(s0 + 620);
    chk("fill_frame_count", rx_q.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("fill_byte[%0d]", k), (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp3[k]);
    chk("fill_first_start", (rx_t.size() > 0) ? rx_t[0] : -1, s0 + 2);
    for (int k = 1; k < 6; k++)
      chk($sformatf("fill_gap[%0d]", k), (k < rx_t.size()) ? rx_t[k] - rx_t[k-1] : -1, 100);
    chk("fill_busy_end", bus.busy, 1'b0);
    chk("fill_full_end", bus.fifo_full, 1'b0);

    // Reset in the middle of data bit 4 (0x4A has bit 4 = 0).
    mon_en = 1'b0;
    bus.byte_in  = 8'h4A;
    bus.byte_stb = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    bus.byte_stb = 1'b0;
    wait_cyc(s0 + 56);
    #2;
    chk("pre_rst_bit4", bus.txd, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", bus.txd, 1'b1);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_full", bus.fifo_full, 1'b0);
    chk("async_rst_overflow", bus.overflow, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_txd", bus.txd, 1'b1);
    chk("post_rst_busy", bus.busy, 1'b0);

    rx_q.delete();
    rx_t.delete();
    mon_en = 1'b1;
    bus.byte_in  = 8'h0D;
    bus.byte_stb = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    bus.byte_stb = 1'b0;
    wait_cyc(s0 + 110);
    chk("post_rst_frames", rx_q.size(), 1);
    chk("post_rst_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h0D);
    chk("post_rst_start", (rx_t.size() > 0) ? rx_t[0] : -1, s0 + 2);
    chk("post_rst_busy_end", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
